itof_pipe: RTL and testbench

- Pipelined signed 32-bit integer to IEEE-754 single-precision converter for the FPU.
- Counterpart to the ftoi direction. Feeds integer-register operands into the float datapath (fadd/fmul inputs).
- Three register stages with a valid/ready handshake and a global stall under backpressure.
- Same float conventions as the rest of the FPU: no denormals; zero is always emitted as +0.

---
 rtl/itof_pipe_if.sv | 20 ++
 rtl/itof_pipe.sv | 105 ++++++++++
 tb/tb_itof_pipe.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/itof_pipe_if.sv
// Stream handshake bundle for the integer-to-float converter.
// Carries the input operand stream and the packed float result stream.
interface itof_pipe_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface

// File: rtl/itof_pipe.sv
// Three-stage signed 32-bit integer to IEEE-754 single converter.
// Stage 1 takes the magnitude, stage 2 normalises, stage 3 rounds and packs.
module itof_pipe #(
  parameter bit RNE = 1'b1
) (
  input logic       clk,
  input logic       rstn,
  itof_pipe_if.slave io
);

  localparam int unsigned W   = 32;
  localparam int unsigned EW  = 8;
  localparam int unsigned MW  = 24;
  localparam int unsigned LZW = 5;
  localparam logic [EW-1:0] EXP_TOP = 8'd158;

  logic stall;

  // Whole pipe freezes when the output is held; bubbles stay in place.
  assign stall       = io.out_valid & ~io.out_ready;
  assign io.in_ready = ~stall;

  // Stage 1: sign / magnitude split
  logic         v1, sign1, zero1;
  logic [W-1:0] mag1;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v1    <= 1'b0;
      sign1 <= 1'b0;
      zero1 <= 1'b0;
      mag1  <= '0;
    end else if (!stall) begin
      v1    <= io.in_valid & io.in_ready;
      sign1 <= io.in_data[W-1];
      zero1 <= (io.in_data == '0);
      mag1  <= io.in_data[W-1] ? W'(-io.in_data) : io.in_data;
    end
  end

  // Stage 2: leading-zero count and normalisation
  logic [LZW-1:0] lz_c;
  logic [W-1:0]   norm_c;
  logic [EW-1:0]  exp_c;

  always_comb begin
    lz_c = LZW'(31);
    for (int i = 0; i < 32; i++) begin
      if (mag1[i]) lz_c = LZW'(31 - i);
    end
    norm_c = mag1 << lz_c;
    exp_c  = EXP_TOP - EW'(lz_c);
  end

  logic          v2, sign2, zero2;
  logic [W-1:0]  norm2;
  logic [EW-1:0] exp2;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v2    <= 1'b0;
      sign2 <= 1'b0;
      zero2 <= 1'b0;
      norm2 <= '0;
      exp2  <= '0;
    end else if (!stall) begin
      v2    <= v1;
      sign2 <= sign1;
      zero2 <= zero1;
      norm2 <= norm_c;
      exp2  <= exp_c;
    end
  end

  // Stage 3: round and pack
  logic [MW-1:0] mant_c;
  logic          guard_c, sticky_c, round_up_c;
  logic [MW:0]   mant_r_c;
  logic [EW-1:0] exp_r_c;
  logic [22:0]   frac_c;
  logic [W-1:0]  packed_c;

  always_comb begin
    mant_c     = norm2[31:8];
    guard_c    = norm2[7];
    sticky_c   = |norm2[6:0];
    round_up_c = RNE ? (guard_c & (sticky_c | mant_c[0])) : 1'b0;
    mant_r_c   = {1'b0, mant_c} + (MW+1)'(round_up_c);
    // A carry out leaves mant_r = 1_0000...; the shifted view is all zeros.
    exp_r_c    = mant_r_c[MW] ? (exp2 + 8'd1) : exp2;
    frac_c     = mant_r_c[MW] ? mant_r_c[23:1] : mant_r_c[22:0];
    packed_c   = zero2 ? '0 : {sign2, exp_r_c, frac_c};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      io.out_valid <= 1'b0;
      io.out_data  <= '0;
    end else if (!stall) begin
      io.out_valid <= v2;
      io.out_data  <= packed_c;
    end
  end

endmodule

// File: tb/tb_itof_pipe.sv
// Scoreboard bench for itof_pipe: one instance per rounding mode, driven in lockstep.
module tb_itof_pipe;

  logic clk = 1'b0;
  logic rstn;

  always #5 clk = ~clk;

  itof_pipe_if ifa ();
  itof_pipe_if ifb ();

  itof_pipe #(.RNE(1'b1)) dut_a (.clk(clk), .rstn(rstn), .io(ifa.slave));
  itof_pipe #(.RNE(1'b0)) dut_b (.clk(clk), .rstn(rstn), .io(ifb.slave));

  int unsigned passed = 0;
  int unsigned total  = 0;
  logic [31:0] qa[$];
  logic [31:0] qb[$];
  int cyc = 0;
  int outs_a = 0;
  int first_acc = -1;
  int first_out = -1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
  endtask

  // Reference conversion built from integer arithmetic on the exact magnitude.
  function automatic logic [31:0] model(input logic [31:0] x, input bit rne);
    logic [63:0] m, q, rem, half;
    int p, sh;
    bit s;
    if (x == 32'd0) return 32'd0;
    s = x[31];
    m = s ? (64'h1_0000_0000 - {32'h0, x}) : {32'h0, x};
    p = 0;
    for (int i = 0; i < 33; i++) if (m[i]) p = i;
    if (p <= 23) begin
      q = m << (23 - p);
    end else begin
      sh   = p - 23;
      q    = m >> sh;
      rem  = m & ((64'd1 << sh) - 64'd1);
      half = 64'd1 << (sh - 1);
      if (rne && (rem > half || (rem == half && q[0]))) q = q + 64'd1;
      if (q == (64'd1 << 24)) begin
        q = q >> 1;
        p = p + 1;
      end
    end
    return {s, 8'(127 + p), q[22:0]};
  endfunction

  // One clock: drive at the falling edge, score transfers, then advance.
  task automatic step(input bit v, input logic [31:0] d, input logic [31:0] ea,
                      input logic [31:0] eb, input bit ordy, output bit acc);
    logic [31:0] e;
    ifa.in_valid = v;  ifb.in_valid = v;
    ifa.in_data  = d;  ifb.in_data  = d;
    ifa.out_ready = ordy; ifb.out_ready = ordy;
    #1;
    if (ifa.out_valid && ifa.out_ready) begin
      if (first_out < 0) first_out = cyc;
      outs_a++;
      chk("a_has_expect", 32'(qa.size() != 0), 32'd1);
      if (qa.size() != 0) begin
        e = qa.pop_front();
        chk("a_out", ifa.out_data, e);
      end
    end
    if (ifb.out_valid && ifb.out_ready) begin
      chk("b_has_expect", 32'(qb.size() != 0), 32'd1);
      if (qb.size() != 0) begin
        e = qb.pop_front();
        chk("b_out", ifb.out_data, e);
      end
    end
    if (ifa.out_valid && !ifa.out_ready) chk("in_ready_stall", 32'(ifa.in_ready), 32'd0);
    acc = v && ifa.in_ready;
    if (acc) begin
      if (first_acc < 0) first_acc = cyc;
      qa.push_back(ea);
      qb.push_back(eb);
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic send(input logic [31:0] d, input logic [31:0] ea, input logic [31:0] eb,
                      input bit ordy);
    bit acc;
    int n;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 100) begin
      step(1'b1, d, ea, eb, ordy, acc);
      n++;
    end
    chk("send_accepted", 32'(acc), 32'd1);
  endtask

  task automatic drain();
    bit acc;
    int n;
    n = 0;
    while ((qa.size() != 0 || qb.size() != 0 || ifa.out_valid) && n < 200) begin
      step(1'b0, 32'd0, 32'd0, 32'd0, 1'b1, acc);
      n++;
    end
    chk("drain_a", 32'(qa.size()), 32'd0);
    chk("drain_b", 32'(qb.size()), 32'd0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    logic [31:0] rin[5];
    logic [31:0] ra[5];
    logic [31:0] rb[5];
    logic [31:0] bpv[6];
    logic [31:0] bpe[6];
    logic [31:0] d;
    bit acc, seen, ordy, v, pend;
    int idx, stall_left, n;

    rstn = 1'b0;
    ifa.in_valid = 1'b0; ifb.in_valid = 1'b0;
    ifa.in_data = '0;    ifb.in_data = '0;
    ifa.out_ready = 1'b0; ifb.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(ifa.out_valid), 32'd0);
    chk("rst_out_data", ifa.out_data, 32'd0);
    chk("rst_in_ready", 32'(ifa.in_ready), 32'd1);
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_out_valid_a", 32'(ifa.out_valid), 32'd0);
    chk("idle_out_valid_b", 32'(ifb.out_valid), 32'd0);
    chk("idle_out_data", ifa.out_data, 32'd0);
    chk("idle_in_ready", 32'(ifb.in_ready), 32'd1);

    // Back-to-back stream with first-result latency
    first_acc = -1; first_out = -1; outs_a = 0;
    send(32'd0,          32'h00000000, 32'h00000000, 1'b1);
    send(32'd1,          32'h3F800000, 32'h3F800000, 1'b1);
    send(32'hFFFFFFFF,   32'hBF800000, 32'hBF800000, 1'b1);
    send(32'd100,        32'h42C80000, 32'h42C80000, 1'b1);
    drain();
    chk("latency", 32'(first_out - first_acc), 32'd3);
    chk("stream_count", 32'(outs_a), 32'd4);

    // Rounding corners in both modes
    rin = '{32'd16777217, 32'd16777219, 32'h7FFFFFFF, 32'h80000000, 32'hFEFFFFFD};
    ra  = '{32'h4B800000, 32'h4B800002, 32'h4F000000, 32'hCF000000, 32'hCB800002};
    rb  = '{32'h4B800000, 32'h4B800001, 32'h4EFFFFFF, 32'hCF000000, 32'hCB800001};
    for (int i = 0; i < 5; i++) send(rin[i], ra[i], rb[i], 1'b1);
    drain();

    // Backpressure: four cycles of out_ready=0 starting at the first result
    bpv = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6};
    bpe = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000, 32'h40C00000};
    idx = 0; seen = 1'b0; stall_left = 4; outs_a = 0; n = 0;
    while (idx < 6 && n < 100) begin
      if (ifa.out_valid) seen = 1'b1;
      ordy = !(seen && stall_left > 0);
      if (!ordy) begin
        stall_left--;
        if (ifa.out_valid) chk("bp_hold", ifa.out_data, 32'h3F800000);
      end
      step(1'b1, bpv[idx], bpe[idx], bpe[idx], ordy, acc);
      if (acc) idx++;
      n++;
    end
    chk("bp_all_accepted", 32'(idx), 32'd6);
    drain();
    chk("bp_count", 32'(outs_a), 32'd6);

    // Reset with three items in flight
    send(32'd5, 32'h40A00000, 32'h40A00000, 1'b1);
    send(32'd6, 32'h40C00000, 32'h40C00000, 1'b1);
    send(32'd7, 32'h40E00000, 32'h40E00000, 1'b1);
    ifa.in_valid = 1'b0; ifb.in_valid = 1'b0;
    rstn = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(ifa.out_valid), 32'd0);
    chk("midrst_out_data", ifb.out_data, 32'd0);
    qa.delete();
    qb.delete();
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    outs_a = 0;
    send(32'd2, 32'h40000000, 32'h40000000, 1'b1);
    drain();
    chk("midrst_count", 32'(outs_a), 32'd1);

    // Random traffic against the model
    pend = 1'b0;
    d = '0;
    for (int k = 0; k < 10000; k++) begin
      if (!pend) begin
        case ($urandom_range(0, 3))
          0: d = $urandom;
          1: d = 32'($urandom_range(0, 400)) - 32'd200;
          2: begin
            d = 32'h0100_0000 + 32'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) d = 32'(-d);
          end
          default: d = $urandom >> $urandom_range(0, 31);
        endcase
        pend = 1'b1;
      end
      v = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 3) != 0);
      step(v, d, model(d, 1'b1), model(d, 1'b0), ordy, acc);
      if (acc) pend = 1'b0;
    end
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
